// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator between NUM_REQ
// requesters; results return tagged with the requester ID on a valid/ready channel.
module cmp_share_arbiter #(
  parameter int WIDTH   = 3,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_eq,
  output logic                     rsp_gt,
  output logic                     rsp_lt,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t            state;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   winner;
  logic [NUM_REQ-1:0] grant_vec;
  logic              found;
  int                idx;

  // Rotating priority search: start just above the last winner and wrap.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    grant_vec = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found          = 1'b1;
        winner         = ID_W'(idx);
        grant_vec[idx] = 1'b1;
      end
    end
  end

  assign req_ready = (state == IDLE) ? grant_vec : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      id_q       <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_eq     <= 1'b0;
      rsp_gt     <= 1'b0;
      rsp_lt     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a       <= req_a[int'(winner)*WIDTH +: WIDTH];
            op_b       <= req_b[int'(winner)*WIDTH +: WIDTH];
            id_q       <= winner;
            last_grant <= winner;
            busy       <= 1'b1;
            state      <= CMP;
          end
        end
        CMP: begin
          rsp_eq    <= (op_a == op_b);
          rsp_gt    <= (op_a > op_b);
          rsp_lt    <= (op_a < op_b);
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // Fields stay frozen until the consumer takes the response.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_eq    <= 1'b0;
            rsp_gt    <= 1'b0;
            rsp_lt    <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  a_result_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |-> $onehot({rsp_eq, rsp_gt, rsp_lt}));

  a_result_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    !rsp_valid |-> !(rsp_eq || rsp_gt || rsp_lt));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable({rsp_id, rsp_eq, rsp_gt, rsp_lt})));

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin / compare model.
module tb_cmp_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [11:0] req_a;
  logic [11:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_eq;
  logic        rsp_gt;
  logic        rsp_lt;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int model_last = 3;
  int ra[4];
  int rb[4];

  cmp_share_arbiter #(.WIDTH(3), .NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference rules: winner is first valid index after the last grant, mod 4.
  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++)
      if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  // Expected {eq, gt, lt} from plain unsigned arithmetic.
  function automatic logic [2:0] exp_res(input int a, input int b);
    if (a == b) return 3'b100;
    if (a > b)  return 3'b010;
    return 3'b001;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int a, input int b);
    ra[i] = a;
    rb[i] = b;
    req_a[i*3 +: 3] = 3'(a);
    req_b[i*3 +: 3] = 3'(b);
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 3;
  endtask

  // Waits for a grant, follows it to the response and accepts it (rsp_ready high).
  task automatic observe_txn(input bit drop, output logic [3:0] v, output logic [3:0] g,
                             output logic [2:0] res, output int rid, output int lat,
                             output int gcyc, output bit ok);
    int n;
    ok = 1'b0; v = '0; g = '0; res = '0; rid = -1; lat = 0; gcyc = 0; n = 0;
    #1;
    while (req_ready == '0 && n < 20) begin
      tick(); #1; n++;
    end
    if (req_ready == '0) return;
    v = req_valid;
    g = req_ready;
    gcyc = cyc;
    tick();
    if (drop) for (int i = 0; i < 4; i++) if (g[i]) req_valid[i] = 1'b0;
    lat = 1;
    #1;
    while (!rsp_valid && lat < 8) begin
      tick(); #1; lat++;
    end
    ok = rsp_valid;
    res = {rsp_eq, rsp_gt, rsp_lt};
    rid = int'(rsp_id);
    tick();
  endtask

  task automatic test_reset();
    logic [3:0] v, g; logic [2:0] r; int rid, lat, gc; bit ok;
    do_reset();
    checks++; if ({rsp_valid, rsp_eq, rsp_gt, rsp_lt, busy, rsp_id} !== 7'b0) $display("[TB] FAIL reset_outputs: got %b want 0", {rsp_valid, rsp_eq, rsp_gt, rsp_lt, busy, rsp_id}); else passes++;
    rsp_ready = 1'b0;
    set_req(1, 7, 2);
    #1;
    checks++; if (req_ready !== 4'b0010) $display("[TB] FAIL reset_pre_grant: got %b want 0010", req_ready); else passes++;
    tick();
    req_valid = '0;
    tick();
    #1;
    checks++; if ({rsp_valid, rsp_gt, rsp_id} !== 4'b1101) $display("[TB] FAIL reset_pre_resp: got %b want 1101", {rsp_valid, rsp_gt, rsp_id}); else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({rsp_valid, rsp_eq, rsp_gt, rsp_lt, busy, rsp_id, req_ready} !== 11'b0) $display("[TB] FAIL reset_async: got %b want 0", {rsp_valid, rsp_eq, rsp_gt, rsp_lt, busy, rsp_id, req_ready}); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    model_last = 3;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      checks++; if ({rsp_valid, busy} !== 2'b00) $display("[TB] FAIL reset_quiet: got %b want 00", {rsp_valid, busy}); else passes++;
    end
    for (int i = 0; i < 4; i++) set_req(i, i, 3 - i);
    observe_txn(1'b1, v, g, r, rid, lat, gc, ok);
    checks++; if (g !== 4'b0001) $display("[TB] FAIL reset_first_winner: got %b want 0001", g); else passes++;
    checks++; if (!ok || rid !== 0 || r !== exp_res(0, 3)) $display("[TB] FAIL reset_first_resp: got ok=%0d id=%0d res=%b want ok=1 id=0 res=%b", ok, rid, r, exp_res(0, 3)); else passes++;
    model_last = 0;
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [3:0] v, g; logic [2:0] r; int rid, lat, gc; bit ok;
    req_valid = '0;
    set_req(2, 7, 7);
    observe_txn(1'b1, v, g, r, rid, lat, gc, ok);
    checks++; if (g !== 4'b0100) $display("[TB] FAIL single_grant: got %b want 0100", g); else passes++;
    checks++; if (!ok || lat !== 2) $display("[TB] FAIL single_latency: got ok=%0d lat=%0d want 2", ok, lat); else passes++;
    checks++; if (rid !== 2 || r !== 3'b100) $display("[TB] FAIL single_resp: got id=%0d res=%b want id=2 res=100", rid, r); else passes++;
    #1;
    checks++; if ({rsp_valid, rsp_eq, rsp_gt, rsp_lt} !== 4'b0) $display("[TB] FAIL single_clear: got %b want 0000", {rsp_valid, rsp_eq, rsp_gt, rsp_lt}); else passes++;
    model_last = 2;
    @(negedge clk);
  endtask

  task automatic test_compare_set();
    logic [3:0] v, g; logic [2:0] r; int rid, lat, gc; bit ok;
    int pa[3] = '{7, 3, 0};
    int pb[3] = '{2, 7, 0};
    for (int k = 0; k < 3; k++) begin
      set_req(0, pa[k], pb[k]);
      observe_txn(1'b1, v, g, r, rid, lat, gc, ok);
      checks++; if (g !== 4'b0001 || !ok || lat !== 2) $display("[TB] FAIL cmp_set_timing: got g=%b ok=%0d lat=%0d want 0001 1 2", g, ok, lat); else passes++;
      checks++; if (rid !== 0 || r !== exp_res(pa[k], pb[k])) $display("[TB] FAIL cmp_set_result: got id=%0d res=%b want id=0 res=%b", rid, r, exp_res(pa[k], pb[k])); else passes++;
      model_last = 0;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] v, g, eg; logic [2:0] r; int rid, lat, gc, prev, exp; bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, $urandom_range(0, 7), $urandom_range(0, 7));
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      exp = rr_pick(req_valid, model_last);
      eg = 4'b0001 << exp;
      observe_txn(1'b0, v, g, r, rid, lat, gc, ok);
      checks++; if (g !== eg) $display("[TB] FAIL rr_grant: got %b want %b", g, eg); else passes++;
      checks++; if (!ok || rid !== exp || r !== exp_res(ra[exp], rb[exp]) || lat !== 2) $display("[TB] FAIL rr_resp: got ok=%0d id=%0d res=%b lat=%0d want id=%0d res=%b lat=2", ok, rid, r, lat, exp, exp_res(ra[exp], rb[exp])); else passes++;
      if (k > 0) begin
        checks++; if (gc - prev !== 3) $display("[TB] FAIL rr_spacing: got %0d want 3", gc - prev); else passes++;
      end
      prev = gc;
      model_last = exp;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [3:0] v, g, eg; logic [2:0] r, er; int rid, lat, gc, exp; bit ok;
    req_valid = '0;
    rsp_ready = 1'b0;
    set_req(0, 5, 1);
    exp = rr_pick(req_valid, model_last);
    eg = 4'b0001 << exp;
    #1;
    checks++; if (req_ready !== eg) $display("[TB] FAIL bp_grant: got %b want %b", req_ready, eg); else passes++;
    model_last = exp;
    er = exp_res(5, 1);
    tick();
    req_valid[0] = 1'b0;
    set_req(3, 2, 6);
    tick();
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if ({rsp_valid, busy, rsp_id, rsp_eq, rsp_gt, rsp_lt} !== {2'b11, 2'd0, er}) $display("[TB] FAIL bp_hold: got %b want %b", {rsp_valid, busy, rsp_id, rsp_eq, rsp_gt, rsp_lt}, {2'b11, 2'd0, er}); else passes++;
      checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL bp_ready: got %b want 0000", req_ready); else passes++;
      tick(); #1;
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    eg = 4'b0001 << rr_pick(req_valid, model_last);
    checks++; if (req_ready !== eg || rsp_valid !== 1'b0) $display("[TB] FAIL bp_release: got ready=%b valid=%b want %b 0", req_ready, rsp_valid, eg); else passes++;
    observe_txn(1'b1, v, g, r, rid, lat, gc, ok);
    checks++; if (!ok || rid !== 3 || r !== exp_res(2, 6) || lat !== 2) $display("[TB] FAIL bp_next: got ok=%0d id=%0d res=%b lat=%0d want id=3 res=001 lat=2", ok, rid, r, lat); else passes++;
    model_last = 3;
  endtask

  task automatic test_withdrawal();
    logic [3:0] v, g; logic [2:0] r; int rid, lat, gc; bit ok;
    req_valid = '0;
    rsp_ready = 1'b1;
    set_req(2, 1, 4);
    #1;
    checks++; if (req_ready !== 4'b0100) $display("[TB] FAIL wd_grant: got %b want 0100", req_ready); else passes++;
    tick();
    set_req(1, 6, 6);
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || {rsp_eq, rsp_gt, rsp_lt} !== 3'b001) $display("[TB] FAIL wd_resp: got v=%b id=%0d res=%b want 1 2 001", rsp_valid, rsp_id, {rsp_eq, rsp_gt, rsp_lt}); else passes++;
    req_valid[1] = 1'b0;
    tick();
    #1;
    checks++; if (req_ready !== 4'b0100) $display("[TB] FAIL wd_regrant: got %b want 0100", req_ready); else passes++;
    @(negedge clk);
    observe_txn(1'b1, v, g, r, rid, lat, gc, ok);
    checks++; if (!ok || rid !== 2 || r !== 3'b001) $display("[TB] FAIL wd_second: got ok=%0d id=%0d res=%b want id=2 res=001", ok, rid, r); else passes++;
    model_last = 2;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) $display("[TB] FAIL wd_idle: got valid=%b ready=%b want 0 0000", rsp_valid, req_ready); else passes++;
      tick();
    end
  endtask

  task automatic test_random();
    logic [3:0] v, g, eg; logic [2:0] r; int rid, lat, gc, exp; bit ok;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, $urandom_range(0, 7), $urandom_range(0, 7));
      if (req_valid == '0) set_req($urandom_range(0, 3), 7, 0);
      exp = rr_pick(req_valid, model_last);
      eg = 4'b0001 << exp;
      observe_txn(1'b1, v, g, r, rid, lat, gc, ok);
      checks++; if (g !== eg) $display("[TB] FAIL rand_grant: got %b want %b (valid=%b last=%0d)", g, eg, v, model_last); else passes++;
      checks++; if (!ok || rid !== exp || r !== exp_res(ra[exp], rb[exp]) || lat !== 2) $display("[TB] FAIL rand_resp: got ok=%0d id=%0d res=%b lat=%0d want id=%0d res=%b lat=2", ok, rid, r, lat, exp, exp_res(ra[exp], rb[exp])); else passes++;
      model_last = exp;
      if ($urandom_range(0, 3) == 0) req_valid[$urandom_range(0, 3)] = 1'b0;
    end
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_compare_set();
    test_round_robin();
    test_backpressure();
    test_withdrawal();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
